// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin arbiter feeding an 8N1 UART transmitter
// Define UART_ARB_LOCK_EN to let a requester hold the line across several bytes via its lock input.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req0_lock,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       req1_lock,
  output logic       tx,
  output logic       busy,
  output logic       owner
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_owner;
  logic          r_ptr;

  logic          w_bit_end;
  logic          w_excl;
  logic          w_winner;
  logic          w_win_valid;
  logic          w_accept;
  logic [7:0]    w_acc_data;

  assign w_bit_end = (r_clk_cnt == LAST_CNT);

`ifdef UART_ARB_LOCK_EN
  // The locked requester is always the owner of the last accepted byte, so r_owner doubles as lock id.
  logic r_locked;
  logic w_owner_lock;

  assign w_owner_lock = r_owner ? req1_lock : req0_lock;
  assign w_excl       = r_locked && w_owner_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked <= 1'b0;
    end else if (w_accept) begin
      r_locked <= w_winner ? req1_lock : req0_lock;
    end else if (r_state == IDLE && !w_owner_lock) begin
      r_locked <= 1'b0;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = req0_lock ^ req1_lock;
  assign w_excl        = 1'b0;
`endif

  // r_ptr already names the non-owner after every frame, so it also resumes correctly after a lock drops.
  always_comb begin
    w_winner = r_ptr;
    if (w_excl) begin
      w_winner = r_owner;
    end else if (req0_valid && !req1_valid) begin
      w_winner = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      w_winner = 1'b1;
    end
  end

  assign w_win_valid = w_winner ? req1_valid : req0_valid;
  assign w_accept    = (r_state == IDLE) && !rst && w_win_valid;
  assign w_acc_data  = w_winner ? req1_data : req0_data;
  assign req0_ready  = w_accept && !w_winner;
  assign req1_ready  = w_accept && w_winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = START;
      START:   if (w_bit_end) w_next = DATA;
      DATA:    if (w_bit_end && r_bit_idx == 3'd7) w_next = STOP;
      STOP:    if (w_bit_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_owner   <= 1'b0;
      r_ptr     <= 1'b0;
    end else begin
      if (r_state == IDLE || w_bit_end) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + CW'(1);
      end
      if (w_accept) begin
        r_shift   <= w_acc_data;
        r_owner   <= w_winner;
        r_bit_idx <= 3'd0;
      end
      if (r_state == DATA && w_bit_end) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (r_state == STOP && w_bit_end) begin
        r_ptr <= ~r_owner;
      end
    end
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (r_state)
      IDLE:    busy = 1'b0;
      START:   tx = 1'b0;
      DATA:    tx = r_shift[r_bit_idx];
      default: tx = 1'b1;
    endcase
  end

  assign owner = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter decoding the serial line
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int FRAME = 10 * N;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req0_lock;
  logic req1_valid, req1_ready, req1_lock;
  logic [7:0] req0_data, req1_data;
  logic tx, busy, owner;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready), .req1_lock(req1_lock),
    .tx(tx), .busy(busy), .owner(owner)
  );

  typedef struct {
    logic [7:0] data;
    logic       own;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] dq0[$], dq1[$];
  logic [7:0] ph0[$], ph1[$];
  int         start_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cnt = 0;
  int         acc_cyc0 = 0;
  bit         in_frame = 0;
  bit         post = 0;
  bit         en0 = 0;
  bit         en1 = 0;
  bit         m_ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.own  = o;
    exp_q.push_back(e);
  endtask

  // Reference: each IDLE grants the sole pending requester, else the one the pointer names;
  // the pointer then names the requester that did not send.
  task automatic run_phase();
    int i0 = 0;
    int i1 = 0;
    bit pick;
    while (i0 < ph0.size() || i1 < ph1.size()) begin
      if (i0 < ph0.size() && i1 < ph1.size()) pick = m_ptr;
      else pick = (i0 < ph0.size()) ? 1'b0 : 1'b1;
      if (pick) begin push_exp(ph1[i1], 1'b1); i1++; end
      else begin push_exp(ph0[i0], 1'b0); i0++; end
      m_ptr = !pick;
    end
    foreach (ph0[i]) dq0.push_back({1'b0, ph0[i]});
    foreach (ph1[i]) dq1.push_back({1'b0, ph1[i]});
    ph0.delete();
    ph1.delete();
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() > 0 || dq0.size() > 0 || dq1.size() > 0 || in_frame || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", int'(t >= 3000), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start();
    int s = start_cnt;
    int t = 0;
    while (start_cnt == s && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("start_timeout", int'(t >= 200), 0);
  endtask

  initial begin : driver
    bit hs0, hs1;
    logic [8:0] t;
    req0_valid = 0; req0_data = 0; req0_lock = 0;
    req1_valid = 0; req1_data = 0; req1_lock = 0;
    forever begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (hs0) acc_cyc0 = cyc;
      @(posedge clk);
      #2;
      if (en0) begin
        if (hs0 && dq0.size() > 0) t = dq0.pop_front();
        if (dq0.size() > 0) begin req0_valid = 1; {req0_lock, req0_data} = dq0[0]; end
        else begin req0_valid = 0; req0_lock = 0; end
      end
      if (en1) begin
        if (hs1 && dq1.size() > 0) t = dq1.pop_front();
        if (dq1.size() > 0) begin req1_valid = 1; {req1_lock, req1_data} = dq1[0]; end
        else begin req1_valid = 0; req1_lock = 0; end
      end
    end
  end

  initial begin : monitor
    int k, bi, pos;
    logic [7:0] rx;
    bit glitch, stop_bad, busy_bad, have;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0;
        post = 0;
      end else begin
        if (post) begin
          post = 0;
          chk("busy_low_after_stop", int'(busy), 0);
        end
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1; k = 0; rx = '0; glitch = 0; stop_bad = 0; busy_bad = 0;
          start_cnt++;
          start_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            have = 0;
            $display("FAIL unexpected_frame: got start bit expected idle at cycle %0d", cyc);
          end else begin
            e = exp_q.pop_front();
            have = 1;
            chk("owner", int'(owner), int'(e.own));
          end
        end
        if (in_frame) begin
          bi = k / N;
          pos = k % N;
          if (busy !== 1'b1) busy_bad = 1;
          if (bi == 0) begin
            if (tx !== 1'b0) glitch = 1;
          end else if (bi <= 8) begin
            if (pos == 0) rx[bi-1] = tx;
            else if (tx !== rx[bi-1]) glitch = 1;
          end else if (tx !== 1'b1) begin
            stop_bad = 1;
          end
          k++;
          if (k == FRAME) begin
            in_frame = 0;
            post = 1;
            if (have) chk("frame_data", int'(rx), int'(e.data));
            chk("bit_timing", int'(glitch), 0);
            chk("stop_bit", int'(stop_bad), 0);
            chk("busy_in_frame", int'(busy_bad), 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s;
    int t;
    rst = 1;
    @(posedge clk);
    #1;
    req0_valid = 1; req0_data = 8'hAA;
    req1_valid = 1; req1_data = 8'hBB;
    @(negedge clk);
    chk("ready0_in_reset", int'(req0_ready), 0);
    chk("ready1_in_reset", int'(req1_ready), 0);
    chk("tx_reset", int'(tx), 1);
    chk("busy_reset", int'(busy), 0);
    chk("owner_reset", int'(owner), 0);
    @(posedge clk);
    #1;
    req0_valid = 0; req1_valid = 0; rst = 0; en0 = 1; en1 = 1; m_ptr = 0;
    repeat (2) @(negedge clk);

    // single 0x55 from req0
    @(posedge clk);
    #1;
    ph0.push_back(8'h55);
    run_phase();
    wait_start();
    chk("start_latency", start_cyc[start_cyc.size()-1] - acc_cyc0, 1);
    drain();

    // both requesters continuously valid: alternation and 10*N+1 spacing
    @(posedge clk);
    #1;
    s = start_cyc.size();
    for (int i = 0; i < 3; i++) begin
      ph0.push_back(8'h41);
      ph1.push_back(8'h42);
    end
    run_phase();
    drain();
    for (int i = 1; i < 6; i++) chk("start_spacing", start_cyc[s+i] - start_cyc[s+i-1], FRAME + 1);

    // one-cycle valid pulse while busy must be ignored
    @(posedge clk);
    #1;
    en0 = 0;
    ph1.push_back(8'h3C);
    run_phase();
    t = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    chk("busy_timeout", int'(t >= 50), 0);
    @(posedge clk);
    #1;
    req0_valid = 1; req0_data = 8'h99;
    @(negedge clk);
    chk("no_ready_while_busy", int'(req0_ready), 0);
    @(posedge clk);
    #1;
    req0_valid = 0;
    drain();
    s = start_cnt;
    repeat (60) @(negedge clk);
    chk("no_extra_frame", start_cnt, s);
    chk("tx_idle_after", int'(tx), 1);
    en0 = 1;

    // reset during data bit 3 of 0xA5, pointer left at 1 beforehand
    @(posedge clk);
    #1;
    ph0.push_back(8'h00);
    run_phase();
    drain();
    @(posedge clk);
    #1;
    ph0.push_back(8'hA5);
    run_phase();
    wait_start();
    repeat (17) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    m_ptr = 0;
    ph0.push_back(8'h61);
    ph1.push_back(8'h62);
    run_phase();
    @(negedge clk);
    chk("tx_after_reset", int'(tx), 1);
    chk("busy_after_reset", int'(busy), 0);
    chk("owner_after_reset", int'(owner), 0);
    drain();

    // req1 streams three locked bytes while req0 waits
    @(posedge clk);
    #1;
    dq1.push_back({1'b1, 8'h10});
    dq1.push_back({1'b1, 8'h11});
    dq1.push_back({1'b1, 8'h12});
`ifdef UART_ARB_LOCK_EN
    push_exp(8'h10, 1'b1); push_exp(8'h11, 1'b1); push_exp(8'h12, 1'b1);
    push_exp(8'h20, 1'b0); push_exp(8'h21, 1'b0);
    m_ptr = 1;
`else
    push_exp(8'h10, 1'b1); push_exp(8'h20, 1'b0); push_exp(8'h11, 1'b1);
    push_exp(8'h21, 1'b0); push_exp(8'h12, 1'b1);
    m_ptr = 0;
`endif
    @(posedge clk);
    #1;
    dq0.push_back({1'b0, 8'h20});
    dq0.push_back({1'b0, 8'h21});
    drain();

    // randomized bursts from both requesters
    for (int r = 0; r < 10; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      @(posedge clk);
      #1;
      for (int i = 0; i < n0; i++) ph0.push_back(8'($urandom));
      for (int i = 0; i < n1; i++) ph1.push_back(8'($urandom));
      run_phase();
      drain();
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
